// File: rtl/gmm_intr_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : gmm_intr_ctrl_v2
// Purpose  : AXI4-Lite interrupt controller for the gmm_processor peripheral.
//            Aggregates up to 32 sources with per-source level/rising-edge
//            detection, enable mask, acknowledge (W1C), software set (W1S)
//            and a global enable, and drives a single irq line.
// Ports    : ACLK, ARESET        - clock, synchronous active-high reset
//            S_AXI_AW*/W*/B*     - AXI4-Lite write address/data/response
//            S_AXI_AR*/R*        - AXI4-Lite read address/data
//            intr_in             - interrupt sources, synchronous to ACLK
//            irq                 - aggregated interrupt, polarity by parameter
// Revision : 2.0 - initial multi-source release
// ============================================================================
module gmm_intr_ctrl_v2 #(
    parameter int                  NUM_INTR           = 1,
    parameter int                  C_S_AXI_ADDR_WIDTH = 5,
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  IRQ_ACTIVE_STATE   = 1,
    parameter logic [NUM_INTR-1:0] ITR_RESET          = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [NUM_INTR-1:0]             intr_in,
    output logic                            irq
);

    localparam int         c_STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam logic       c_IRQ_IDLE = (IRQ_ACTIVE_STATE == 0);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Register word indices (addr[4:2])
    localparam logic [2:0] c_REG_GIE  = 3'd0;
    localparam logic [2:0] c_REG_IER  = 3'd1;
    localparam logic [2:0] c_REG_ISR  = 3'd2;
    localparam logic [2:0] c_REG_IAR  = 3'd3;
    localparam logic [2:0] c_REG_IPR  = 3'd4;
    localparam logic [2:0] c_REG_ITR  = 3'd5;
    localparam logic [2:0] c_REG_ISWR = 3'd6;
    localparam logic [2:0] c_REG_NONE = 3'd7;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_ACK  = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_ACK  = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    logic [1:0]                    r_wstate;
    logic [1:0]                    r_rstate;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                          r_gie;
    logic [NUM_INTR-1:0]           r_ier;
    logic [NUM_INTR-1:0]           r_isr;
    logic [NUM_INTR-1:0]           r_itr;
    logic [NUM_INTR-1:0]           r_intr_q;
    logic                          r_irq;

    logic [C_S_AXI_DATA_WIDTH-1:0] w_byte_mask;
    logic [NUM_INTR-1:0]           w_wmask;
    logic [NUM_INTR-1:0]           w_wbits;
    logic                          w_wr_fire;
    logic [2:0]                    w_wr_sel;
    logic [2:0]                    w_rd_sel;
    logic [NUM_INTR-1:0]           w_ack_clr;
    logic [NUM_INTR-1:0]           w_sw_set;
    logic [NUM_INTR-1:0]           w_hw_set;
    logic [NUM_INTR-1:0]           w_isr_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
    logic                          w_unused_ok;

    // Address/data bits outside the decoded range are intentionally ignored.
    assign w_unused_ok = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

    // ------------------------------------------------------------------------
    // Write-side decode. The register write happens in the W_ACK cycle, where
    // AWVALID/WVALID are still held by the master, so no capture is needed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_byte_mask = '0;
        for (int b = 0; b < c_STRB_W; b++) begin
            w_byte_mask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
        end
    end

    assign w_wmask   = w_byte_mask[NUM_INTR-1:0];
    assign w_wbits   = S_AXI_WDATA[NUM_INTR-1:0] & w_wmask;
    assign w_wr_fire = (r_wstate == c_W_ACK);
    assign w_wr_sel  = S_AXI_AWADDR[4:2];
    assign w_rd_sel  = S_AXI_ARADDR[4:2];

    assign w_ack_clr = (w_wr_fire && (w_wr_sel == c_REG_IAR))  ? w_wbits : '0;
    assign w_sw_set  = (w_wr_fire && (w_wr_sel == c_REG_ISWR)) ? w_wbits : '0;

    // Level sources set every cycle they are high; edge sources only on a
    // 0->1 transition relative to the previous-cycle sample.
    assign w_hw_set  = (intr_in & ~r_itr) | (intr_in & ~r_intr_q & r_itr);

    // Set terms are OR-ed after the clear so a coincident event is not lost.
    assign w_isr_next = (r_isr & ~w_ack_clr) | w_hw_set | w_sw_set;

    // ------------------------------------------------------------------------
    // Interrupt registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        // Loaded during reset as well, so a source already high at release
        // does not look like a rising edge.
        r_intr_q <= intr_in;
        if (ARESET) begin
            r_gie <= 1'b0;
            r_ier <= '0;
            r_isr <= '0;
            r_itr <= ITR_RESET;
            r_irq <= c_IRQ_IDLE;
        end else begin
            if (w_wr_fire) begin
                case (w_wr_sel)
                    c_REG_GIE: if (S_AXI_WSTRB[0]) r_gie <= S_AXI_WDATA[0];
                    c_REG_IER: r_ier <= (r_ier & ~w_wmask) | w_wbits;
                    c_REG_ITR: r_itr <= (r_itr & ~w_wmask) | w_wbits;
                    default:   ;
                endcase
            end
            r_isr <= w_isr_next;
            r_irq <= (r_gie & (|(r_isr & r_ier))) ^ c_IRQ_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= c_W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        r_wstate  <= c_W_ACK;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                c_W_ACK: begin
                    r_wstate  <= c_W_RESP;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= (w_wr_sel == c_REG_NONE) ? c_RESP_SLVERR : c_RESP_OKAY;
                end
                c_W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_wstate <= c_W_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: begin
                    r_wstate  <= c_W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read data mux. Sampled in R_ACK from register state before any
    // same-cycle write takes effect.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_rd_sel)
            c_REG_GIE: w_rdata = C_S_AXI_DATA_WIDTH'(r_gie);
            c_REG_IER: w_rdata = C_S_AXI_DATA_WIDTH'(r_ier);
            c_REG_ISR: w_rdata = C_S_AXI_DATA_WIDTH'(r_isr);
            c_REG_IPR: w_rdata = C_S_AXI_DATA_WIDTH'(r_isr & r_ier);
            c_REG_ITR: w_rdata = C_S_AXI_DATA_WIDTH'(r_itr);
            default:   w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= c_R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_rstate  <= c_R_ACK;
                        r_arready <= 1'b1;
                    end
                end
                c_R_ACK: begin
                    r_rstate  <= c_R_DATA;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b1;
                    r_rdata   <= w_rdata;
                    r_rresp   <= (w_rd_sel == c_REG_NONE) ? c_RESP_SLVERR : c_RESP_OKAY;
                end
                c_R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rstate <= c_R_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_rstate  <= c_R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gmm_intr_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmm_intr_ctrl_v2
// Purpose  : Self-checking bench for gmm_intr_ctrl_v2 (NUM_INTR=4,
//            active-high irq, ITR reset value 4'h2). Register-access vectors
//            come from a table; expected AXI responses are queued when a
//            transaction is issued and compared when the DUT responds.
// Revision : 2.0 - initial release
// ============================================================================
module tb_gmm_intr_ctrl_v2;

    localparam int         NI    = 4;
    localparam logic [3:0] ITR_R = 4'h2;

    localparam logic [4:0] A_GIE  = 5'h00;
    localparam logic [4:0] A_IER  = 5'h04;
    localparam logic [4:0] A_ISR  = 5'h08;
    localparam logic [4:0] A_IAR  = 5'h0C;
    localparam logic [4:0] A_IPR  = 5'h10;
    localparam logic [4:0] A_ITR  = 5'h14;
    localparam logic [4:0] A_ISWR = 5'h18;
    localparam logic [4:0] A_NONE = 5'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [NI-1:0] intr_in = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t rd_q[$];
    exp_t wr_q[$];

    gmm_intr_ctrl_v2 #(
        .NUM_INTR           (NI),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_S_AXI_DATA_WIDTH (32),
        .IRQ_ACTIVE_STATE   (1),
        .ITR_RESET          (ITR_R)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .intr_in       (intr_in),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input bit w, input logic [4:0] a, input logic [31:0] d,
                                    input logic [3:0] s, input logic [31:0] ed,
                                    input logic [1:0] er, input string n);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s;
        v.exp_data = ed; v.exp_resp = er; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input string name);
        exp_t e;
        exp_t got;
        int n;
        e.data = '0; e.resp = er; e.name = name;
        wr_q.push_back(e);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) check({name, " awready timeout"}, {31'b0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        got = wr_q.pop_front();
        if (!bvalid) check({got.name, " bvalid timeout"}, {31'b0, bvalid}, 32'd1);
        else         check({got.name, " bresp"}, {30'b0, bresp}, {30'b0, got.resp});
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string name);
        exp_t e;
        exp_t got;
        int n;
        e.data = ed; e.resp = er; e.name = name;
        rd_q.push_back(e);
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) check({name, " arready timeout"}, {31'b0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        got = rd_q.pop_front();
        if (!rvalid) begin
            check({got.name, " rvalid timeout"}, {31'b0, rvalid}, 32'd1);
        end else begin
            check({got.name, " rdata"}, rdata, got.data);
            if (got.resp != 2'b00) check({got.name, " rresp"}, {30'b0, rresp}, {30'b0, got.resp});
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        int n;

        // Register-access table: reset values, responses, RW and strobes
        add_vec(0, A_GIE,  0, 0, 32'h0, 2'b00, "rst GIE");
        add_vec(0, A_IER,  0, 0, 32'h0, 2'b00, "rst IER");
        add_vec(0, A_ISR,  0, 0, 32'h0, 2'b00, "rst ISR");
        add_vec(0, A_IAR,  0, 0, 32'h0, 2'b00, "rst IAR");
        add_vec(0, A_IPR,  0, 0, 32'h0, 2'b00, "rst IPR");
        add_vec(0, A_ITR,  0, 0, 32'h2, 2'b00, "rst ITR");
        add_vec(0, A_ISWR, 0, 0, 32'h0, 2'b00, "rst ISWR");
        add_vec(0, A_NONE, 0, 0, 32'h0, 2'b10, "rd unmapped");
        add_vec(1, A_NONE, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, "wr unmapped");
        add_vec(1, A_ITR,  32'h0, 4'hF, 0, 2'b00, "wr ITR 0");
        add_vec(0, A_ITR,  0, 0, 32'h0, 2'b00, "rd ITR 0");
        add_vec(1, A_GIE,  32'h1, 4'hF, 0, 2'b00, "wr GIE");
        add_vec(1, A_IER,  32'h5, 4'hF, 0, 2'b00, "wr IER");
        add_vec(0, A_GIE,  0, 0, 32'h1, 2'b00, "rd GIE");
        add_vec(0, A_IER,  0, 0, 32'h5, 2'b00, "rd IER");
        add_vec(1, A_IER,  32'hF, 4'h0, 0, 2'b00, "wr IER strb0");
        add_vec(0, A_IER,  0, 0, 32'h5, 2'b00, "IER after strb0");
        add_vec(1, A_IER,  32'hFFFF_FFFF, 4'hE, 0, 2'b00, "wr IER upper lanes");
        add_vec(0, A_IER,  0, 0, 32'h5, 2'b00, "IER after upper lanes");
        add_vec(1, A_IAR,  32'hF, 4'hF, 0, 2'b00, "wr IAR idle");
        add_vec(0, A_IAR,  0, 0, 32'h0, 2'b00, "rd IAR");

        // Reset state of outputs
        repeat (3) @(negedge clk);
        check("rst irq", {31'b0, irq}, 32'd0);
        check("rst handshake outs", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("rst resp/data", rdata | {28'b0, bresp, rresp}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) axi_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, vecs[i].name);
            else               axi_rd(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].name);
        end

        // Level source 0: one-cycle pulse, irq two cycles later
        @(negedge clk);
        intr_in = 4'h1;
        @(negedge clk);
        intr_in = 4'h0;
        check("irq before latency", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("irq after latency", {31'b0, irq}, 32'd1);
        axi_rd(A_IPR, 32'h1, 2'b00, "IPR level");
        axi_wr(A_IAR, 32'h1, 4'hF, 2'b00, "ack level");
        check("irq after ack", {31'b0, irq}, 32'd0);
        axi_rd(A_IPR, 32'h0, 2'b00, "IPR after ack");

        // Edge mode: held input flags once, ack stays clear while still high
        axi_wr(A_ITR, 32'hF, 4'hF, 2'b00, "wr ITR F");
        intr_in = 4'h4;
        axi_rd(A_ISR, 32'h4, 2'b00, "ISR edge set");
        axi_wr(A_IAR, 32'h4, 4'hF, 2'b00, "ack edge");
        axi_rd(A_ISR, 32'h0, 2'b00, "ISR edge held high");
        check("irq edge held high", {31'b0, irq}, 32'd0);
        intr_in = 4'h0;
        repeat (2) @(negedge clk);
        intr_in = 4'h4;
        repeat (3) @(negedge clk);
        check("irq edge re-set", {31'b0, irq}, 32'd1);
        axi_rd(A_ISR, 32'h4, 2'b00, "ISR edge re-set");
        intr_in = 4'h0;
        axi_wr(A_IAR, 32'h4, 4'hF, 2'b00, "ack edge 2");

        // Level source high across the ack: set wins
        axi_wr(A_ITR, 32'h0, 4'hF, 2'b00, "wr ITR level");
        intr_in = 4'h1;
        repeat (2) @(negedge clk);
        axi_wr(A_IAR, 32'h1, 4'hF, 2'b00, "ack while high");
        axi_rd(A_ISR, 32'h1, 2'b00, "ISR set wins");
        check("irq set wins", {31'b0, irq}, 32'd1);
        intr_in = 4'h0;
        axi_wr(A_IAR, 32'h1, 4'hF, 2'b00, "ack after low");
        axi_rd(A_ISR, 32'h0, 2'b00, "ISR cleared");

        // Software set with the source masked, then unmasked
        axi_wr(A_IER, 32'h0, 4'hF, 2'b00, "IER 0");
        axi_wr(A_ISWR, 32'h8, 4'hF, 2'b00, "ISWR 8");
        axi_rd(A_ISR, 32'h8, 2'b00, "ISR sw set");
        axi_rd(A_IPR, 32'h0, 2'b00, "IPR masked");
        check("irq masked", {31'b0, irq}, 32'd0);
        axi_wr(A_IER, 32'h8, 4'hF, 2'b00, "IER 8");
        check("irq unmasked", {31'b0, irq}, 32'd1);
        axi_wr(A_IAR, 32'h8, 4'hF, 2'b00, "ack sw");
        check("irq sw acked", {31'b0, irq}, 32'd0);

        // AWVALID early, then a stalled BREADY
        @(negedge clk);
        awaddr = A_IER; wdata = 32'hA; wstrb = 4'hF; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no ready on AW only", {30'b0, awready, wready}, 32'd0);
        end
        wvalid = 1'b1;
        @(negedge clk);
        check("ready once both valid", {30'b0, awready, wready}, 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bvalid/bresp held", {29'b0, bvalid, bresp}, 32'h4);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid dropped", {31'b0, bvalid}, 32'd0);
        axi_rd(A_IER, 32'hA, 2'b00, "IER after late W");

        // Reset while RVALID is pending
        @(negedge clk);
        araddr = A_IER; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid before reset", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rvalid after reset", {30'b0, rvalid, arready}, 32'd0);
        rst = 1'b0;
        axi_rd(A_IER, 32'h0, 2'b00, "IER after reset");
        axi_rd(A_ITR, 32'h2, 2'b00, "ITR after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gmm_intr_ctrl_v2.md
# gmm_intr_ctrl_v2

Parametrised AXI4-Lite interrupt controller for the gmm_processor peripheral. It is the successor to the single-source interrupt slave. It aggregates up to 32 interrupt sources from the DMA master and CSR logic, with per-source level or rising-edge detection, enable masking, acknowledge, software trigger and a global enable. It drives one `irq` line of configurable polarity to the host.

## Interface
- NUM_INTR, 1: number of interrupt sources, 1..32.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; registers decode on addr[4:2].
- C_S_AXI_DATA_WIDTH, 32: fixed at 32.
- IRQ_ACTIVE_STATE, 1: 1 = `irq` active-high, 0 = active-low.
- ITR_RESET, 0: reset value of the type register, NUM_INTR bits; bit = 1 selects edge mode.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA  in  32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
- S_AXI_RDATA  out  32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1
- intr_in  in  NUM_INTR  interrupt sources, synchronous to ACLK.
- irq  out  1  aggregated interrupt, polarity set by IRQ_ACTIVE_STATE.

## Operation
- Register map. Only bits [NUM_INTR-1:0] are implemented; unimplemented bits read 0.
  - 0x00 GIE: bit0 is the global enable (RW).
  - 0x04 IER: enable mask (RW).
  - 0x08 ISR: raw status (RO).
  - 0x0C IAR: acknowledge; write-1-to-clear ISR, reads 0.
  - 0x10 IPR: pending = ISR & IER (RO).
  - 0x14 ITR: type per source, 0 = level, 1 = rising edge (RW).
  - 0x18 ISWR: software set; write-1-to-set ISR, reads 0.
  - 0x1C: unmapped; read returns RDATA=0, RRESP=SLVERR; write is ignored with BRESP=SLVERR.
  - All other responses are OKAY.
- WSTRB masks each byte lane on RW, W1C and W1S writes.
- Status set conditions:
  - Level source: set in every cycle intr_in[i]=1.
  - Edge source: set when intr_in[i]=1 and intr_q[i]=0. intr_q is the previous-cycle sample.
- Status is sticky. It clears only on an IAR write of 1.
- Set and clear in the same cycle on the same bit: set wins, so no event is lost. A level source still high therefore stays asserted after ack.
- irq_next = GIE[0] & |(ISR & IER). `irq` is registered and driven as irq_next XOR (IRQ_ACTIVE_STATE==0).
- Changing ITR does not alter ISR.
- Write FSM states: W_IDLE -> W_ACK -> W_RESP -> W_IDLE.
  - W_IDLE -> W_ACK when AWVALID & WVALID.
  - W_ACK: AWREADY=WREADY=1 for exactly one cycle; the register updates at the end of this cycle.
  - W_RESP: BVALID held until BREADY, then return to W_IDLE.
  - AW-only or W-only valid: wait in W_IDLE; no ready is asserted.
- Read FSM states: R_IDLE -> R_ACK -> R_DATA -> R_IDLE.
  - R_IDLE -> R_ACK when ARVALID.
  - R_ACK: ARREADY=1 for one cycle; address is captured.
  - R_DATA: RDATA/RRESP are registered from the captured address and held stable with RVALID until RREADY.
- Reads and writes are independent and may overlap. A read of a register in the same cycle it is written returns the pre-write value.

## Timing
- Reset values:
  - All AXI outputs are 0. RDATA=0, BRESP=RRESP=0.
  - GIE, IER and ISR are 0. ITR = ITR_RESET.
  - irq is inactive: 0 if IRQ_ACTIVE_STATE=1, else 1.
- During reset, intr_q loads intr_in. An edge source already high at reset release is therefore not flagged.
- ARESET mid-transaction aborts it. Valids and readies drop in the next cycle, and the FSMs return to idle.
- Write latency: valids seen in cycle N -> ready in N+1 -> register updated and BVALID in N+2.
- Read latency: ARVALID in cycle N -> ARREADY in N+1 -> RVALID in N+2.
- Max throughput is one write per 3 cycles and one read per 3 cycles, assuming immediate BREADY/RREADY.
- Interrupt latency: intr_in rises in cycle N -> ISR bit set after edge N -> irq active in cycle N+2.
- Ack: IAR handshake in cycle N -> ISR cleared after edge N (unless re-set in the same cycle) -> irq inactive in N+2.

## Test plan
- Reset, then read 0x00–0x18: all 0 except ITR=ITR_RESET. Read 0x1C: RRESP=2'b10. irq is inactive.
- NUM_INTR=4, level mode:
  - Write GIE=1, IER=0x5.
  - Drive intr_in=0x1 for 1 cycle: irq active 2 cycles later, IPR=0x1.
  - Write IAR=0x1: irq inactive. IPR=0.
- Edge mode, ITR=0xF:
  - Hold intr_in[2]=1 for 10 cycles: ISR=0x4. Ack clears it and it stays 0 while the input is still high.
  - Next rising edge re-sets it.
- Level source held high while IAR=0x1 is written in the same cycle: ISR bit remains 1 and irq stays active.
- IER=0x0, write ISWR=0x8: ISR=0x8, IPR=0, irq inactive. Then IER=0x8: irq active.
- Handshake checks:
  - AWVALID raised 5 cycles before WVALID: no AWREADY until both are valid.
  - BREADY held low 4 cycles: BVALID and BRESP stay stable.
  - WSTRB=0x0 write to IER leaves IER unchanged.
  - Assert ARESET during R_DATA: RVALID=0 next cycle.
